cdf5_3_lifting: RTL and testbench

Streaming 1-D forward CDF 5/3 (LeGall) integer wavelet lifting stage for 8-bit pixel lines.
- Each accepted clock takes one sample pair (even x[2n], odd x[2n+1]) plus the next even sample x[2n+2].
- Emits one approximation coefficient s[n] and one detail coefficient d[n] per pair, through a 2-stage pipeline.
- Sits between the line/image buffer reader and the coefficient writer of the wavelet transformer; a 2-D transform runs it on rows, then on columns.

---
 rtl/cdf5_3_lifting.sv | 196 +++++++++++++++++++
 tb/tb_cdf5_3_lifting.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/cdf5_3_lifting.sv
// Streaming forward CDF 5/3 (LeGall) lifting stage: one (s, d) coefficient pair per accepted sample pair.
// Optional macro CDF_SAT_EN selects saturating instead of wrapping output formatting.
module cdf5_3_lifting #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              en,
    input  logic              dis,
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    output logic [DATA_W-1:0] out_s,
    output logic [DATA_W-1:0] out_d,
    output logic              result
);

    localparam int IW = DATA_W + 2;
    localparam int SW = IW + 1;

    localparam logic signed [SW-1:0] S_MAX = SW'((2 ** DATA_W) - 1);
    localparam logic signed [IW-1:0] D_MAX = IW'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [IW-1:0] D_MIN = -D_MAX - IW'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t state_r;

    logic                     accept_s;
    logic                     first_s;

    logic [DATA_W-1:0]        x0_r, x1_r, x2_r;
    logic                     v0_r, f0_r;

    logic signed [IW-1:0]     sum_s;
    logic signed [IW-1:0]     d_calc_s;

    logic signed [IW-1:0]     d1_r;
    logic [DATA_W-1:0]        xe_r;
    logic                     v1_r, f1_r;

    logic signed [IW-1:0]     d_prev_r;
    logic signed [IW-1:0]     dp_s;
    logic signed [SW-1:0]     t_s;
    logic signed [SW-1:0]     s_calc_s;

    logic [DATA_W-1:0]        out_s_r, out_d_r;
    logic                     result_r;

    // Approximation formatting: wrap to DATA_W bits or clamp to the unsigned range.
    function automatic logic [DATA_W-1:0] fmt_s(input logic signed [SW-1:0] v);
`ifdef CDF_SAT_EN
        if (v < $signed({SW{1'b0}})) begin
            return {DATA_W{1'b0}};
        end else if (v > S_MAX) begin
            return {DATA_W{1'b1}};
        end else begin
            return v[DATA_W-1:0];
        end
`else
        return v[DATA_W-1:0];
`endif
    endfunction

    // Detail formatting: wrap to DATA_W bits or clamp to the signed range.
    function automatic logic [DATA_W-1:0] fmt_d(input logic signed [IW-1:0] v);
`ifdef CDF_SAT_EN
        if (v < D_MIN) begin
            return D_MIN[DATA_W-1:0];
        end else if (v > D_MAX) begin
            return D_MAX[DATA_W-1:0];
        end else begin
            return v[DATA_W-1:0];
        end
`else
        return v[DATA_W-1:0];
`endif
    endfunction

    // Pair acceptance: dis always wins, en marks the first pair of a line.
    always_comb begin
        accept_s = 1'b0;
        first_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (en && !dis) begin
                    accept_s = 1'b1;
                    first_s  = 1'b1;
                end else begin
                    accept_s = 1'b0;
                    first_s  = 1'b0;
                end
            end
            ST_RUN: begin
                if (dis) begin
                    accept_s = 1'b0;
                    first_s  = 1'b0;
                end else begin
                    accept_s = 1'b1;
                    first_s  = en;
                end
            end
            default: begin
                accept_s = 1'b0;
                first_s  = 1'b0;
            end
        endcase
    end

    // Line state machine.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_r <= (en && !dis) ? ST_RUN : ST_IDLE;
                ST_RUN:  state_r <= dis ? ST_IDLE : ST_RUN;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Input capture of the accepted pair.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x0_r <= {DATA_W{1'b0}};
            x1_r <= {DATA_W{1'b0}};
            x2_r <= {DATA_W{1'b0}};
            v0_r <= 1'b0;
            f0_r <= 1'b0;
        end else begin
            x0_r <= in0;
            x1_r <= in1;
            x2_r <= in2;
            v0_r <= accept_s;
            f0_r <= first_s;
        end
    end

    // Predict step; the operand sum is non-negative so the halving shift is exact floor.
    always_comb begin
        sum_s    = $signed({2'b00, x0_r}) + $signed({2'b00, x2_r});
        d_calc_s = $signed({2'b00, x1_r}) - (sum_s >>> 1);
    end

    // Stage 1 register: detail coefficient and the matching even sample.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            d1_r <= {IW{1'b0}};
            xe_r <= {DATA_W{1'b0}};
            v1_r <= 1'b0;
            f1_r <= 1'b0;
        end else begin
            d1_r <= d_calc_s;
            xe_r <= x0_r;
            v1_r <= v0_r;
            f1_r <= f0_r;
        end
    end

    // Update step; one extra bit keeps d[n-1] + d[n] + 2 from overflowing.
    always_comb begin
        dp_s     = f1_r ? d1_r : d_prev_r;
        t_s      = SW'(dp_s) + SW'(d1_r) + SW'(2);
        s_calc_s = $signed({3'b000, xe_r}) + (t_s >>> 2);
    end

    // Stage 2 register: formatted outputs, valid flag and stored previous detail.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_s_r  <= {DATA_W{1'b0}};
            out_d_r  <= {DATA_W{1'b0}};
            result_r <= 1'b0;
            d_prev_r <= {IW{1'b0}};
        end else begin
            result_r <= v1_r;
            if (v1_r) begin
                out_s_r  <= fmt_s(s_calc_s);
                out_d_r  <= fmt_d(d1_r);
                d_prev_r <= d1_r;
            end else begin
                out_s_r  <= out_s_r;
                out_d_r  <= out_d_r;
                d_prev_r <= d_prev_r;
            end
        end
    end

    assign out_s  = out_s_r;
    assign out_d  = out_d_r;
    assign result = result_r;

endmodule

// File: tb/tb_cdf5_3_lifting.sv
// Directed self-checking bench for cdf5_3_lifting with hand-computed coefficients.
module tb_cdf5_3_lifting;

    logic       clk;
    logic       resetn;
    logic       en;
    logic       dis;
    logic [7:0] in0, in1, in2;
    logic [7:0] out_s, out_d;
    logic       result;

    int total;
    int bad;

`ifdef CDF_SAT_EN
    localparam logic [7:0] NEG200_D = 8'h80;
    localparam logic [7:0] BIG_S    = 8'hFF;
    localparam logic [7:0] BIG_D    = 8'h7F;
`else
    localparam logic [7:0] NEG200_D = 8'h38;
    localparam logic [7:0] BIG_S    = 8'h3F;
    localparam logic [7:0] BIG_D    = 8'h80;
`endif

    cdf5_3_lifting #(.DATA_W(8)) dut (
        .clk    (clk),
        .resetn (resetn),
        .en     (en),
        .dis    (dis),
        .in0    (in0),
        .in1    (in1),
        .in2    (in2),
        .out_s  (out_s),
        .out_d  (out_d),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic r, input logic [7:0] s, input logic [7:0] d);
        chk({tag, ".result"}, {7'd0, result}, {7'd0, r});
        chk({tag, ".s"}, out_s, s);
        chk({tag, ".d"}, out_d, d);
    endtask

    task automatic drive(input logic e, input logic ds, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        en  = e;
        dis = ds;
        in0 = a;
        in1 = b;
        in2 = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        resetn = 1'b0;
        en     = 1'b0;
        dis    = 1'b0;
        in0    = 8'd0;
        in1    = 8'd0;
        in2    = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_out("reset", 1'b0, 8'd0, 8'd0);
        @(negedge clk);
        resetn = 1'b1;
        drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);

        // two pairs, then end of line
        drive(1'b1, 1'b0, 8'd10, 8'd30, 8'd10);
        drive(1'b0, 1'b0, 8'd10, 8'd50, 8'd10);
        drive(1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
        chk_out("pair0", 1'b1, 8'd20, 8'd20);
        drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        chk_out("pair1", 1'b1, 8'd25, 8'd40);
        drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        chk_out("hold", 1'b0, 8'd25, 8'd40);

        // en while RUN restarts the line: symmetric extension again
        drive(1'b1, 1'b0, 8'd10, 8'd50, 8'd10);
        drive(1'b1, 1'b0, 8'd10, 8'd30, 8'd10);
        drive(1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
        chk_out("restart_a", 1'b1, 8'd30, 8'd40);
        drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        chk_out("restart_b", 1'b1, 8'd20, 8'd20);
        drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        chk("restart_end", {7'd0, result}, 8'd0);

        // constant line of 8 pairs
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                drive(i == 0, 1'b0, 8'd100, 8'd100, 8'd100);
            end else begin
                drive(1'b0, i == 8, 8'd0, 8'd0, 8'd0);
            end
            if (i >= 2) begin
                chk_out($sformatf("const%0d", i - 2), 1'b1, 8'd100, 8'd0);
            end
        end
        drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        chk("const_end", {7'd0, result}, 8'd0);

        // large negative detail
        drive(1'b1, 1'b0, 8'd200, 8'd0, 8'd200);
        drive(1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
        drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        chk_out("neg_d", 1'b1, 8'd100, NEG200_D);

        // approximation above 255 and detail of +128
        drive(1'b1, 1'b0, 8'd255, 8'd255, 8'd0);
        drive(1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
        drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        chk_out("big", 1'b1, BIG_S, BIG_D);

        // en and dis together in IDLE: nothing accepted, stays IDLE
        drive(1'b1, 1'b1, 8'd10, 8'd30, 8'd10);
        drive(1'b0, 1'b0, 8'd10, 8'd30, 8'd10);
        drive(1'b0, 1'b0, 8'd10, 8'd30, 8'd10);
        chk("endis_a", {7'd0, result}, 8'd0);
        drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        chk("endis_b", {7'd0, result}, 8'd0);

        // reset while outputs are valid
        drive(1'b1, 1'b0, 8'd10, 8'd30, 8'd10);
        drive(1'b0, 1'b0, 8'd10, 8'd30, 8'd10);
        drive(1'b0, 1'b0, 8'd10, 8'd30, 8'd10);
        chk("pre_reset", {7'd0, result}, 8'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk_out("mid_reset", 1'b0, 8'd0, 8'd0);
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 8'd10, 8'd30, 8'd10);
            chk($sformatf("post_reset%0d", i), {7'd0, result}, 8'd0);
        end
        drive(1'b1, 1'b0, 8'd10, 8'd30, 8'd10);
        drive(1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
        drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        chk_out("after_reset", 1'b1, 8'd20, 8'd20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
